// File: rtl/upstream_risk_engine.sv
// upstream_risk_engine: per-client pre-trade risk table (acc, canc, max) with a
// serial read-evaluate-write request FSM and a fixed-latency accept/headroom response.
module upstream_risk_engine #(
    parameter int N_CLIENTS = 32,
    parameter int ID_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
    parameter int AMT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_kind,
    input  logic [ID_W-1:0]         req_client,
    input  logic [AMT_W-1:0]        req_amount,
    output logic                    rsp_valid,
    output logic                    rsp_accept,
    output logic [ID_W-1:0]         rsp_client,
    output logic signed [AMT_W+1:0] rsp_headroom,
    output logic                    init_busy
);
    localparam int W = AMT_W + 2;

    typedef enum logic [2:0] {INIT, IDLE, READ, EVAL, WRITE} state_t;
    state_t state, state_n;

    logic [ID_W-1:0]      idx, cli, rd_idx;
    logic [1:0]           kind;
    logic [AMT_W-1:0]     amt;
    logic [3*AMT_W-1:0]   mem [N_CLIENTS];
    logic [AMT_W-1:0]     acc_r, canc_r, max_r;
    logic [AMT_W-1:0]     acc_e, canc_e, max_e, acc_sat;
    logic [AMT_W-1:0]     acc_n, canc_n, max_n;
    logic [AMT_W:0]       sum;
    logic                 wr_en, cli_ok, req_ok, ok_ord, ok_can, accept, last_idx;
    logic signed [W-1:0]  acc_s, canc_s, max_s, amt_s, outst, expo, head;
    logic signed [W-1:0]  acc_es, canc_es, max_es;

    if (N_CLIENTS >= (1 << ID_W)) begin : g_full
        assign cli_ok = 1'b1;
    end else begin : g_part
        assign cli_ok = {1'b0, cli} < (ID_W+1)'(N_CLIENTS);
    end

    assign req_ready = state == IDLE;
    assign init_busy = state == INIT;
    assign last_idx  = idx == ID_W'(N_CLIENTS - 1);
    assign rd_idx    = cli_ok ? cli : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            INIT:    state_n = last_idx ? IDLE : INIT;
            IDLE:    state_n = req_valid ? READ : IDLE;
            READ:    state_n = EVAL;
            EVAL:    state_n = WRITE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            kind <= '0;
            cli  <= '0;
            amt  <= '0;
        end else begin
            if (state == INIT) idx <= idx + 1'b1;
            if (req_valid && req_ready) begin
                kind <= req_kind;
                cli  <= req_client;
                amt  <= req_amount;
            end
        end
    end

    // Record table: cleared one entry per cycle in INIT, registered read every cycle
    always_ff @(posedge clk) begin
        if (state == INIT) mem[idx] <= '0;
        else if (state == WRITE && wr_en) mem[cli] <= {acc_n, canc_n, max_n};
        {acc_r, canc_r, max_r} <= mem[rd_idx];
    end

    assign acc_s  = W'(acc_r);
    assign canc_s = W'(canc_r);
    assign max_s  = W'(max_r);
    assign amt_s  = W'(amt);
    assign outst  = acc_s - canc_s;
    assign expo   = outst + amt_s;
    assign ok_ord = expo < max_s;
    assign ok_can = amt_s <= outst;
    assign sum    = {1'b0, acc_r} + {1'b0, amt};
    assign acc_sat = sum[AMT_W] ? '1 : sum[AMT_W-1:0];

    assign req_ok = cli_ok && kind != 2'b11;
    assign accept = req_ok && (kind == 2'b00 ? ok_ord : kind == 2'b10 ? ok_can : 1'b1);

    assign acc_e  = (accept && kind == 2'b00) ? acc_sat : acc_r;
    assign canc_e = (accept && kind == 2'b10) ? canc_r + amt : canc_r;
    assign max_e  = (accept && kind == 2'b01) ? amt : max_r;

    assign acc_es  = W'(acc_e);
    assign canc_es = W'(canc_e);
    assign max_es  = W'(max_e);
    assign head    = req_ok ? max_es - (acc_es - canc_es) : '0;

    // Decision and post-operation record are captured at the end of EVAL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_accept   <= 1'b0;
            rsp_client   <= '0;
            rsp_headroom <= '0;
            wr_en        <= 1'b0;
            acc_n        <= '0;
            canc_n       <= '0;
            max_n        <= '0;
        end else begin
            rsp_valid <= state == EVAL;
            if (state == EVAL) begin
                rsp_accept   <= accept;
                rsp_client   <= cli;
                rsp_headroom <= head;
                wr_en        <= accept;
                acc_n        <= acc_e;
                canc_n       <= canc_e;
                max_n        <= max_e;
            end
        end
    end
endmodule

// File: tb/tb_upstream_risk_engine.sv
// tb_upstream_risk_engine: directed vector table, corner sequences and random
// traffic checked against a per-client integer reference model.
module tb_upstream_risk_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [1:0] req_kind = '0;
    logic [4:0] req_client = '0;
    logic [15:0] req_amount = '0;
    logic rsp_valid, rsp_accept, init_busy;
    logic [4:0] rsp_client;
    logic signed [17:0] rsp_headroom;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_acc[32], m_canc[32], m_max[32];

    typedef struct {
        logic [1:0] k;
        int c;
        int a;
        bit acc;
        int head;
    } vec_t;
    vec_t tbl[16];

    upstream_risk_engine dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_client(req_client), .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_accept(rsp_accept), .rsp_client(rsp_client),
        .rsp_headroom(rsp_headroom), .init_busy(init_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_acc[i] = 0; m_canc[i] = 0; m_max[i] = 0;
        end
    endfunction

    // Risk rules applied to plain integers; the record is updated only on accept
    function automatic void model(input int k, input int c, input int a, output bit acc, output int head);
        int o = m_acc[c] - m_canc[c];
        acc = 1'b0;
        head = 0;
        if (k == 3) return;
        if (k == 0) begin
            acc = (o + a) < m_max[c];
            if (acc) m_acc[c] = (m_acc[c] + a > 65535) ? 65535 : m_acc[c] + a;
        end else if (k == 1) begin
            acc = 1'b1;
            m_max[c] = a;
        end else begin
            acc = a <= o;
            if (acc) m_canc[c] = m_canc[c] + a;
        end
        head = m_max[c] - (m_acc[c] - m_canc[c]);
    endfunction

    task automatic wait_init(input string nm);
        int n = 0;
        while (init_busy && n < 100) begin
            chk({nm, "_ready_low"}, req_ready, 0);
            @(negedge clk);
            n++;
        end
        chk({nm, "_init_cycles"}, n, 32);
        chk({nm, "_ready_after"}, req_ready, 1);
    endtask

    task automatic issue(input int k, input int c, input int a,
                         output bit acc, output int head, output int lat, output int cl);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_kind = 2'(k);
        req_client = 5'(c);
        req_amount = 16'(a);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk("rsp_valid_wait", rsp_valid, 1);
        acc = rsp_accept;
        head = rsp_headroom;
        cl = rsp_client;
    endtask

    task automatic run(input int k, input int c, input int a, input bit e_acc, input int e_head, input string nm);
        bit acc;
        int head, lat, cl;
        issue(k, c, a, acc, head, lat, cl);
        chk({nm, "_accept"}, acc, e_acc);
        chk({nm, "_headroom"}, head, e_head);
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_client"}, cl, c);
    endtask

    initial begin
        bit e_acc, e_acc2, seen;
        int e_head, e_head2, h1, h2, n, pulses;

        tbl[0]  = '{2'd0, 3, 100,   1'b0, 0};
        tbl[1]  = '{2'd1, 3, 500,   1'b1, 500};
        tbl[2]  = '{2'd0, 3, 300,   1'b1, 200};
        tbl[3]  = '{2'd0, 3, 200,   1'b0, 200};
        tbl[4]  = '{2'd0, 3, 199,   1'b1, 1};
        tbl[5]  = '{2'd2, 3, 150,   1'b1, 151};
        tbl[6]  = '{2'd2, 3, 400,   1'b0, 151};
        tbl[7]  = '{2'd0, 4, 1,     1'b0, 0};
        tbl[8]  = '{2'd0, 4, 0,     1'b0, 0};
        tbl[9]  = '{2'd3, 3, 5,     1'b0, 0};
        tbl[10] = '{2'd0, 3, 0,     1'b1, 151};
        tbl[11] = '{2'd1, 7, 60000, 1'b1, 60000};
        tbl[12] = '{2'd0, 7, 50000, 1'b1, 10000};
        tbl[13] = '{2'd2, 7, 50000, 1'b1, 60000};
        tbl[14] = '{2'd0, 7, 50000, 1'b1, 44465};
        tbl[15] = '{2'd2, 7, 15535, 1'b1, 60000};

        repeat (3) @(negedge clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_accept", rsp_accept, 0);
        chk("reset_rsp_client", rsp_client, 0);
        chk("reset_rsp_headroom", rsp_headroom, 0);
        chk("reset_init_busy", init_busy, 1);
        rst = 1'b0;
        model_clear();
        wait_init("boot");

        for (int i = 0; i < 16; i++) begin
            model(tbl[i].k, tbl[i].c, tbl[i].a, e_acc, e_head);
            run(tbl[i].k, tbl[i].c, tbl[i].a, tbl[i].acc, tbl[i].head, $sformatf("vec%0d", i));
        end

        // Two queued requests with req_valid held high throughout
        model(0, 5, 10, e_acc, e_head);
        model(1, 5, 77, e_acc2, e_head2);
        @(negedge clk);
        req_valid = 1'b1; req_kind = 2'd0; req_client = 5'd5; req_amount = 16'd10;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 h1 = cyc;
        req_kind = 2'd1; req_amount = 16'd77;
        pulses = 0; n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                pulses++;
                chk("b2b_first_accept", rsp_accept, e_acc);
                chk("b2b_first_headroom", rsp_headroom, e_head);
            end
        end
        @(posedge clk);
        #1 h2 = cyc;
        req_valid = 1'b0;
        chk("b2b_gap", h2 - h1, 4);
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                chk("b2b_second_accept", rsp_accept, e_acc2);
                chk("b2b_second_headroom", rsp_headroom, e_head2);
            end
        end
        chk("b2b_pulses", pulses, 2);

        for (int i = 0; i < 200; i++) begin
            int k, c, a;
            k = $urandom_range(0, 3);
            c = $urandom_range(0, 7);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 3000);
            model(k, c, a, e_acc, e_head);
            run(k, c, a, e_acc, e_head, $sformatf("rnd%0d", i));
        end

        // Reset lands while a set-max for client 3 is in EVAL
        @(negedge clk);
        req_valid = 1'b1; req_kind = 2'd1; req_client = 5'd3; req_amount = 16'd900;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        chk("midrst_no_rsp", seen, 0);
        chk("midrst_init_busy", init_busy, 1);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_headroom", rsp_headroom, 0);
        rst = 1'b0;
        model_clear();
        wait_init("midrst");
        model(0, 3, 1, e_acc, e_head);
        run(0, 3, 1, 1'b0, 0, "post_rst_c3");
        model(0, 7, 0, e_acc, e_head);
        run(0, 7, 0, e_acc, e_head, "post_rst_c7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/upstream_risk_engine.md
# upstream_risk_engine

Parametrised successor to the single-client upstream pre-trade checker. It holds a per-client record table covering accumulated orders, cancelled orders and max-to-trade, and serialises order, cancel and set-max requests through one synchronous read-evaluate-write FSM. Each request receives an accept/reject decision and a post-operation headroom figure. It sits between the order-entry front end and the downstream order path, replacing the combinational/fork-based check with a valid/ready request port and a fixed-latency response.

## Interface
- N_CLIENTS, 32, number of client records; client ids 0..N_CLIENTS-1 are valid.
- ID_W, $clog2(N_CLIENTS) (minimum 1), client id width.
- AMT_W, 16, width of amounts, accumulated, cancelled and max fields.
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  engine can accept; transfer when req_valid && req_ready.
- req_kind  input  2  00 order, 01 set max, 10 cancel, 11 reserved (rejected, no write).
- req_client  input  ID_W  client id.
- req_amount  input  AMT_W  unsigned amount / new max.
- rsp_valid  output  1  one-cycle response pulse, no backpressure.
- rsp_accept  output  1  decision, qualified by rsp_valid.
- rsp_client  output  ID_W  echo of request client.
- rsp_headroom  output  AMT_W+2  signed, max − (acc − canc) after the operation.
- init_busy  output  1  table clear in progress.

## Operation
- Record per client: acc, canc, max (each AMT_W, unsigned). Table read latency is 1 cycle, single port.
- FSM states: INIT → IDLE → READ → EVAL → WRITE → IDLE.
- INIT: writes zero to one record per cycle, index 0..N_CLIENTS-1. Sets init_busy=1 and req_ready=0. Moves to IDLE after the last index.
- IDLE: req_ready=1. On handshake, latch kind/client/amount and issue the table read.
- EVAL: widen all terms to AMT_W+2 signed. exposure = acc − canc + amount. outstanding = acc − canc.
  - Order: accept iff exposure < max (strict, max zero-extended). On accept, acc_new = min(acc + amount, 2^AMT_W − 1). On reject, record is unchanged.
  - Set max: always accept. max_new = amount. acc and canc are unchanged.
  - Cancel: accept iff amount ≤ outstanding. On accept, canc_new = canc + amount. On reject, record is unchanged.
  - Reserved kind, or client ≥ N_CLIENTS: reject, no write, rsp_headroom=0.
- WRITE: write the record only if accepted. Assert rsp_valid, rsp_accept, rsp_client and rsp_headroom = max_new − (acc_new − canc_new) using the post-operation values.
- Amount 0 is legal. An order of 0 is accepted iff outstanding < max and leaves the record unchanged.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_accept=0, rsp_client=0, rsp_headroom=0, init_busy=1. FSM enters INIT.
- Init duration is N_CLIENTS cycles after rst deasserts. req_ready rises the cycle after the last clear write.
- Handshake at edge T (IDLE) → READ at T+1 → EVAL at T+2 → rsp_valid high during cycle T+3 (WRITE). Back in IDLE at T+4.
- Maximum throughput is one request per 4 cycles. req_ready is low in READ, EVAL and WRITE.
- A write to a client at T+3 is visible to a request for the same client accepted at T+4. There is no hazard window.
- rsp_* outputs hold their value between pulses. Only rsp_valid qualifies them.
- rst asserted in any state, including mid-request: outputs go to reset values immediately. No response is issued for the in-flight request. The whole table is re-cleared.

## Test plan
- Reset release with N_CLIENTS=32 → init_busy high 32 cycles, req_ready low throughout. Then order client 3, amount 100, max 0 → rsp_accept=0, rsp_headroom=0, rsp_valid exactly 3 cycles after handshake.
- Client 3: set max 500 → accept, headroom 500. Order 300 → accept, headroom 200. Order 200 (exposure 500 = max) → reject, headroom 200. Order 199 → accept, headroom 1.
- Continuing client 3 (acc 499): cancel 150 → accept, headroom 151. Cancel 400 (outstanding 349) → reject, headroom 151. Client 4 is untouched: order 1 → reject, headroom 0.
- Saturation, client 7: max 60000. Order 50000 → accept. Cancel 50000 → accept. Order 50000 → accept, acc=65535, headroom 44465.
- Back-to-back: req_valid held high with two queued requests → second handshake exactly 4 cycles after the first, one rsp_valid per request. Reserved kind 11 → reject, no record change.
- Assert rst during EVAL of client 3 set-max 900 → no rsp_valid, init_busy reasserts, full re-clear. A subsequent client 3 order of 1 is rejected with headroom 0.
